mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of addresses and data words on all ports.
REQ-002 Parameter MAX_LS_STREAK, default 4: consecutive load/store grants allowed while an instruction request waits; range 1..15.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; held high until if_done.
REQ-006 if_addr  input  WORD_SIZE  fetch address; stable while if_req is high.
REQ-007 if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  output  WORD_SIZE  fetched word; holds until the next fetch completes.
REQ-009 ls_req  input  1  load/store request; held high until ls_done.
REQ-010 ls_we  input  1  1 = store, 0 = load; stable while ls_req is high.
REQ-011 ls_addr  input  WORD_SIZE  load/store address.
REQ-012 ls_wdata  input  WORD_SIZE  store data.
REQ-013 ls_done  output  1  one-cycle pulse: load/store complete.
REQ-014 ls_rdata  output  WORD_SIZE  load data; holds until the next load completes; unchanged by stores.
REQ-015 mem_op  output  mem_op_t  MEM_IDLE, MEM_READ_EN or MEM_WRITE_EN to the shared memory port.
REQ-016 mem_addr  output  WORD_SIZE  shared-port address.
REQ-017 mem_wdata  output  WORD_SIZE  shared-port write data.
REQ-018 mem_rdata  input  WORD_SIZE  shared-port read data, valid when mem_ready is high.
REQ-019 mem_ready  input  1  memory completes the current access in this cycle.

Function
REQ-020 FSM states: IDLE, BUSY_IF, BUSY_LS; exactly one active.
REQ-021 Requests are sampled only in IDLE; in BUSY states req inputs are ignored for arbitration.
REQ-022 IDLE, only if_req high -> BUSY_IF; only ls_req high -> BUSY_LS; neither -> stay IDLE.
REQ-023 IDLE, both high: BUSY_LS unless streak counter equals MAX_LS_STREAK, then BUSY_IF.
REQ-024 On leaving IDLE, address, we and wdata of the winner are latched; memory outputs are driven only from latched registers.
REQ-025 BUSY_IF: mem_op = MEM_READ_EN, mem_addr = latched if_addr.
REQ-026 BUSY_LS: mem_op = MEM_WRITE_EN if latched we else MEM_READ_EN; mem_addr/mem_wdata = latched values.
REQ-027 IDLE: mem_op = MEM_IDLE; mem_addr and mem_wdata hold last values.
REQ-028 BUSY state with mem_ready low: stay, outputs unchanged (unbounded wait states).
REQ-029 BUSY state with mem_ready high: return to IDLE; next cycle pulse the owner's done for exactly one cycle; reads register mem_rdata into if_rdata or ls_rdata on that same edge.
REQ-030 Minimum latency: req high in cycle N, mem_ready high in N+1 -> done high in N+2; next grant sampled in N+2, next access in N+3.
REQ-031 Streak counter (4 bits): +1 on each LS grant made while if_req high; cleared on any IF grant; saturates at MAX_LS_STREAK.
REQ-032 LS grants made while if_req is low leave the counter unchanged.
REQ-033 if_done and ls_done are never high in the same cycle.
REQ-034 Requester dropping req mid-access: access still completes and done still pulses.

Reset
REQ-035 Reset: state IDLE, mem_op MEM_IDLE, mem_addr/mem_wdata/if_rdata/ls_rdata zero, done outputs low, counter zero.
REQ-036 Reset during a BUSY state aborts the access immediately; no done pulse follows.
REQ-037 First grant possible on the first rising edge after reset deasserts.

Verification
REQ-038 if_req only, if_addr=0x100, mem_ready=1, mem_rdata=0x00000013 -> MEM_READ_EN addr 0x100 one cycle; if_done pulse; if_rdata=0x13.
REQ-039 ls_req store addr 0x2000 wdata 0xDEADBEEF, mem_ready low 3 cycles -> MEM_WRITE_EN held 4 cycles, one ls_done, ls_rdata unchanged.
REQ-040 if_req and ls_req held continuously, MAX_LS_STREAK=4, mem_ready=1 -> grant order LS,LS,LS,LS,IF repeating.
REQ-041 Both requests at once after reset -> LS granted first; IF granted next; counter 1 then 0.
REQ-042 Reset asserted mid BUSY_LS -> mem_op MEM_IDLE immediately, no ls_done, all outputs at reset values.
REQ-043 if_req dropped during BUSY_IF wait -> access completes, single if_done, return to IDLE with mem_op MEM_IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg / mem_arbiter
//
// Purpose:
//   Arbitrates a single shared memory port between an instruction-fetch
//   requester (read only) and a load/store requester (read or write).
//   Load/store normally wins a tie, but an instruction fetch that keeps
//   losing is forced through after MAX_LS_STREAK consecutive load/store
//   grants, so fetch can never be starved.
//
// Parameters:
//   WORD_SIZE      width of addresses and data words on every port
//   MAX_LS_STREAK  load/store grants allowed in a row while a fetch waits (1..15)
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request and address (held until if_done)
//   if_done/if_rdata      one-cycle completion pulse and fetched word
//   ls_req/ls_we          load/store request, 1 = store
//   ls_addr/ls_wdata      load/store address and store data
//   ls_done/ls_rdata      one-cycle completion pulse and load data
//   mem_op                MEM_IDLE / MEM_READ_EN / MEM_WRITE_EN
//   mem_addr/mem_wdata    shared-port address and write data
//   mem_rdata/mem_ready   shared-port read data and access-complete strobe
// -----------------------------------------------------------------------------

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_READ_EN  = 2'd1,
        MEM_WRITE_EN = 2'd2
    } mem_op_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_done,
    output logic [WORD_SIZE-1:0] if_rdata,

    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [WORD_SIZE-1:0] ls_addr,
    input  logic [WORD_SIZE-1:0] ls_wdata,
    output logic                 ls_done,
    output logic [WORD_SIZE-1:0] ls_rdata,

    output mem_op_t              mem_op,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    state_t               state_q,     state_d;
    mem_op_t              mem_op_q,    mem_op_d;
    logic [WORD_SIZE-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 lat_we_q,    lat_we_d;
    logic                 if_done_q,   if_done_d;
    logic                 ls_done_q,   ls_done_d;
    logic [WORD_SIZE-1:0] if_rdata_q,  if_rdata_d;
    logic [WORD_SIZE-1:0] ls_rdata_q,  ls_rdata_d;
    logic [3:0]           streak_q,    streak_d;

    logic                 grant_if;
    logic                 grant_ls;

    // Arbitration decision, only meaningful while IDLE. Load/store wins a
    // tie unless the fetch has already been passed over STREAK_MAX times.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            grant_ls = ls_req && !(if_req && (streak_q == STREAK_MAX));
            grant_if = if_req && !grant_ls;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_we_d    = lat_we_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        streak_d    = streak_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if) begin
                    state_d    = BUSY_IF;
                    mem_op_d   = MEM_READ_EN;
                    mem_addr_d = if_addr;
                    streak_d   = 4'd0;
                end else if (grant_ls) begin
                    state_d     = BUSY_LS;
                    mem_op_d    = ls_we ? MEM_WRITE_EN : MEM_READ_EN;
                    mem_addr_d  = ls_addr;
                    mem_wdata_d = ls_wdata;
                    lat_we_d    = ls_we;
                    // Only grants that make a fetch wait count toward the streak.
                    if (if_req && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end

            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_op_d   = MEM_IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end

            BUSY_LS: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_op_d  = MEM_IDLE;
                    ls_done_d = 1'b1;
                    // Stores leave the last load result untouched.
                    if (!lat_we_q) begin
                        ls_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mem_op_d = MEM_IDLE;
            end
        endcase
    end

    // Reset aborts any access in flight; the done flops clear with it, so
    // no completion pulse can follow an aborted access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_op_q    <= MEM_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_we_q    <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            streak_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_we_q    <= lat_we_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            streak_q    <= streak_d;
        end
    end

    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter: a table of single-requester
// transactions with a completion scoreboard, plus hand-written sequences for
// reset during an access, a simultaneous request pair, and the fetch
// starvation limit.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_done;
    logic [W-1:0] if_rdata;
    logic         ls_req;
    logic         ls_we;
    logic [W-1:0] ls_addr;
    logic [W-1:0] ls_wdata;
    logic         ls_done;
    logic [W-1:0] ls_rdata;
    mem_op_t      mem_op;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_ready;

    mem_arbiter #(.WORD_SIZE(W), .MAX_LS_STREAK(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         is_ls;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        int           waits;
        logic         drop;
    } txn_t;

    typedef struct {
        logic         is_ls;
        logic         we;
        logic [W-1:0] rdata;
    } exp_done_t;

    int           checks;
    int           errors;
    logic [W-1:0] exp_if_rdata;
    logic [W-1:0] exp_ls_rdata;
    exp_done_t    sb_q[$];
    int           grant_q[$];
    txn_t         tbl[7];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        if_req    = 1'b0;
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one transaction from a single requester, acts as the memory
    // (inserting t.waits wait states), and checks the port and completion.
    task automatic run_txn(input txn_t t);
        exp_done_t e;
        mem_op_t   exp_op;
        logic      seen;
        int        busy;
        e.is_ls = t.is_ls;
        e.we    = t.we;
        e.rdata = t.rdata;
        sb_q.push_back(e);
        exp_op = (t.is_ls && t.we) ? MEM_WRITE_EN : MEM_READ_EN;
        if (t.is_ls) begin
            ls_req = 1'b1; ls_we = t.we; ls_addr = t.addr; ls_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        mem_rdata = t.rdata;
        mem_ready = 1'b0;
        busy = 0;
        seen = 1'b0;
        for (int c = 1; c <= 64 && !seen; c++) begin
            @(negedge clock);
            if (mem_op != MEM_IDLE) begin
                busy++;
                chk("busy_op", 32'(mem_op), 32'(exp_op));
                chk("busy_addr", mem_addr, t.addr);
                if (t.is_ls) chk("busy_wdata", mem_wdata, t.wdata);
                if (t.drop && busy == 1) begin
                    if_req = 1'b0;
                    ls_req = 1'b0;
                end
                mem_ready = (busy == t.waits + 1);
            end else begin
                mem_ready = 1'b0;
            end
            chk("wrong_done", 32'(t.is_ls ? if_done : ls_done), 32'd0);
            if (t.is_ls ? ls_done : if_done) begin
                seen   = 1'b1;
                if_req = 1'b0;
                ls_req = 1'b0;
                e = sb_q.pop_front();
                chk("latency", 32'(c), 32'(t.waits + 2));
                chk("busy_cycles", 32'(busy), 32'(t.waits + 1));
                if (e.is_ls && !e.we) exp_ls_rdata = e.rdata;
                if (!e.is_ls)         exp_if_rdata = e.rdata;
                chk("if_rdata", if_rdata, exp_if_rdata);
                chk("ls_rdata", ls_rdata, exp_ls_rdata);
                chk("streak_single", 32'(dut.streak_q), 32'd0);
            end
        end
        if (!seen) begin
            fail_now("txn_timeout");
            sb_q.delete();
            if_req = 1'b0;
            ls_req = 1'b0;
        end
        mem_ready = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("idle_op", 32'(mem_op), 32'(MEM_IDLE));
            chk("idle_addr_hold", mem_addr, t.addr);
            chk("idle_dones", {30'd0, if_done, ls_done}, 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        //           is_ls we    addr           wdata          rdata          waits drop
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0013, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 3, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h1111_2222, 32'hCAFE_F00D, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h1234_5678, 2, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,         32'h7777_7777, 0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0BAD_F00D, 5, 1'b0};

        apply_reset();
        chk("rst_op", 32'(mem_op), 32'(MEM_IDLE));
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
        chk("rst_streak", 32'(dut.streak_q), 32'd0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset in the middle of a store with wait states.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_2000; ls_wdata = 32'hDEAD_BEEF;
        mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_rst_op", 32'(mem_op), 32'(MEM_WRITE_EN));
        reset = 1'b1;
        #1;
        chk("midrst_op", 32'(mem_op), 32'(MEM_IDLE));
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_wdata", mem_wdata, 32'h0);
        chk("midrst_if_rdata", if_rdata, 32'h0);
        chk("midrst_ls_rdata", ls_rdata, 32'h0);
        chk("midrst_dones", {30'd0, if_done, ls_done}, 32'd0);
        ls_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_no_done", 32'(ls_done), 32'd0);
            chk("post_rst_op", 32'(mem_op), 32'(MEM_IDLE));
        end
        mem_ready = 1'b0;

        // Simultaneous requests: load/store first, then the fetch.
        apply_reset();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_3000;
        mem_rdata = 32'hA5A5_0001;
        @(negedge clock);
        chk("tie_first_op", 32'(mem_op), 32'(MEM_READ_EN));
        chk("tie_first_addr", mem_addr, 32'h0000_3000);
        chk("tie_streak1", 32'(dut.streak_q), 32'd1);
        ls_req = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        chk("tie_ls_done", {30'd0, if_done, ls_done}, 32'd1);
        chk("tie_ls_rdata", ls_rdata, 32'hA5A5_0001);
        mem_rdata = 32'hA5A5_0002;
        @(negedge clock);
        chk("tie_second_addr", mem_addr, 32'h0000_0104);
        chk("tie_streak0", 32'(dut.streak_q), 32'd0);
        @(negedge clock);
        chk("tie_if_done", {30'd0, if_done, ls_done}, 32'd2);
        chk("tie_if_rdata", if_rdata, 32'hA5A5_0002);
        if_req = 1'b0;
        mem_ready = 1'b0;

        // Both requests held continuously: LS x4 then IF, repeating.
        apply_reset();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0800;
        mem_rdata = 32'h0000_0055;
        mem_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) grant_q.push_back(1);
            grant_q.push_back(0);
        end
        for (int c = 0; c < 100 && grant_q.size() > 0; c++) begin
            @(negedge clock);
            chk("never_both_done", 32'(if_done & ls_done), 32'd0);
            if (mem_op != MEM_IDLE) begin
                int k;
                k = grant_q.pop_front();
                chk("streak_grant_addr", mem_addr, (k == 1) ? 32'h0000_0800 : 32'h0000_0400);
            end
        end
        if (grant_q.size() != 0) begin
            fail_now("streak_timeout");
            grant_q.delete();
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        apply_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
